// File: rtl/mm_pkg.sv
// Shared constants, FSM state type and packing helper for the 3x3 matrix
// multiplier stream controller.
package mm_pkg;

  localparam int unsigned DW = 18;
  localparam int unsigned N  = 3;
  localparam int unsigned PW = N * N * DW;

  typedef enum logic [1:0] {
    LOAD_A,
    LOAD_B,
    CAPTURE,
    SEND
  } state_t;

  // Bit offset of element (i,j), both 1-based, inside a packed matrix bus.
  function automatic int unsigned elem_lsb(input int unsigned i, input int unsigned j);
    return ((i - 1) * N + (j - 1)) * DW;
  endfunction

endpackage

// File: rtl/mmult3x3.sv
// Combinational 3x3 matrix multiplier, CO = AI * BI, element arithmetic
// truncated to DW bits (modulo 2^DW).
module mmult3x3
  import mm_pkg::*;
(
  input  logic [PW-1:0] AI,
  input  logic [PW-1:0] BI,
  output logic [PW-1:0] CO
);

  logic [DW-1:0] acc;

  always_comb begin
    CO  = '0;
    acc = '0;
    for (int unsigned i = 1; i <= N; i++) begin
      for (int unsigned j = 1; j <= N; j++) begin
        acc = '0;
        for (int unsigned k = 1; k <= N; k++) begin
          acc = acc + AI[elem_lsb(i, k) +: DW] * BI[elem_lsb(k, j) +: DW];
        end
        CO[elem_lsb(i, j) +: DW] = acc;
      end
    end
  end

endmodule

// File: rtl/mm_stream_ctrl.sv
// Streaming front/back end for mmult3x3: loads A then B one element per
// handshake, captures the product and streams C out row-major.
// Optional MM_CSUM_EN appends an XOR checksum word to each result frame.
module mm_stream_ctrl
  import mm_pkg::*;
#(
  parameter int unsigned DW = mm_pkg::DW,
  parameter int unsigned N  = mm_pkg::N
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          busy
);

  localparam int unsigned NE = N * N;
  localparam int unsigned BW = NE * DW;
  localparam logic [3:0] LAST_IN = 4'(NE - 1);
`ifdef MM_CSUM_EN
  localparam logic [3:0] LAST_OUT = 4'(NE);
`else
  localparam logic [3:0] LAST_OUT = 4'(NE - 1);
`endif

  state_t        state, state_next;
  logic [3:0]    idx;
  logic [BW-1:0] a_reg, b_reg, res_reg, prod;
  logic [DW-1:0] csum;
  logic          in_fire, out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  mmult3x3 u_mmult (
    .AI (a_reg),
    .BI (b_reg),
    .CO (prod)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD_A;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      LOAD_A:  if (in_fire && idx == LAST_IN) state_next = LOAD_B;
      LOAD_B:  if (in_fire && idx == LAST_IN) state_next = CAPTURE;
      CAPTURE: state_next = SEND;
      SEND:    if (out_fire && idx == LAST_OUT) state_next = LOAD_A;
      default: state_next = LOAD_A;
    endcase
  end

  // idx is shared: operand slot while loading, result word while sending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx     <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      res_reg <= '0;
    end else begin
      case (state)
        LOAD_A: if (in_fire) begin
          a_reg[idx * DW +: DW] <= in_data;
          idx <= (idx == LAST_IN) ? '0 : idx + 4'd1;
        end
        LOAD_B: if (in_fire) begin
          b_reg[idx * DW +: DW] <= in_data;
          idx <= (idx == LAST_IN) ? '0 : idx + 4'd1;
        end
        CAPTURE: begin
          res_reg <= prod;
          idx     <= '0;
        end
        SEND: if (out_fire) begin
          idx <= (idx == LAST_OUT) ? '0 : idx + 4'd1;
        end
        default: idx <= '0;
      endcase
    end
  end

  always_comb begin
    csum = '0;
    for (int unsigned e = 0; e < NE; e++) csum = csum ^ res_reg[e * DW +: DW];
  end

  always_comb begin
    in_ready  = (state == LOAD_A) || (state == LOAD_B);
    out_valid = (state == SEND);
    out_last  = (state == SEND) && (idx == LAST_OUT);
    busy      = (state != LOAD_A) || (idx != '0);
    out_data  = '0;
    if (state == SEND) begin
`ifdef MM_CSUM_EN
      if (idx < 4'(NE)) out_data = res_reg[idx * DW +: DW];
      else              out_data = csum;
`else
      out_data = res_reg[idx * DW +: DW];
`endif
    end
  end

endmodule

// File: tb/tb_mm_stream_ctrl.sv
// Directed self-checking bench for mm_stream_ctrl with a result scoreboard;
// honours MM_CSUM_EN for the optional checksum word.
module tb_mm_stream_ctrl;

  localparam int DW = 18;
`ifdef MM_CSUM_EN
  localparam int NW = 10;
`else
  localparam int NW = 9;
`endif

  typedef logic [DW-1:0] mat_t [9];

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;

  int checks   = 0;
  int failures = 0;
  logic [DW:0] exp_q [$];

  mm_stream_ctrl #(.DW(18), .N(3)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference product, row-major, truncated to DW bits.
  task automatic push_expected(input mat_t a, input mat_t b);
    logic [DW-1:0] c, x;
    x = '0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        c = '0;
        for (int k = 0; k < 3; k++) c = c + DW'(a[i*3+k] * b[k*3+j]);
        x = x ^ c;
        exp_q.push_back({(NW == 9) && (i*3+j == 8), c});
      end
    end
    if (NW == 10) exp_q.push_back({1'b1, x});
  endtask

  task automatic send_elem(input logic [DW-1:0] d, input int gap);
    int n;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("in_ready_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input mat_t a, input mat_t b, input bit gaps);
    push_expected(a, b);
    for (int e = 0; e < 9; e++) send_elem(a[e], gaps ? int'($urandom_range(0, 3)) : 0);
    for (int e = 0; e < 9; e++) send_elem(b[e], gaps ? int'($urandom_range(0, 3)) : 0);
  endtask

  task automatic recv_word(input int stall);
    logic [DW:0] exp, held;
    int n;
    out_ready = 1'b0;
    n = 0;
    while (!out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("out_valid_wait", out_valid, 1);
    if (stall > 0) begin
      held = {out_last, out_data};
      repeat (stall) begin
        @(negedge clk);
        check("stall_hold", {out_valid, out_last, out_data}, {1'b1, held});
      end
    end
    out_ready = 1'b1;
    if (exp_q.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0d expected=none", out_data);
    end else begin
      exp = exp_q.pop_front();
      check("result_word", {out_last, out_data}, exp);
    end
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic recv_frame(input bit stalls);
    for (int w = 0; w < NW; w++) recv_word((stalls && (w % 2 == 0)) ? 5 : 0);
  endtask

  mat_t ramp_a, ramp_b, wrap_m, ident;
  logic [DW:0] exp_w;
  int cyc, first_ov, n;
  bit done;

  initial begin
    for (int e = 0; e < 9; e++) begin
      ramp_a[e] = DW'(e);
      ramp_b[e] = DW'(e + 1);
      wrap_m[e] = DW'(512);
      ident[e]  = (e % 4 == 0) ? DW'(1) : '0;
    end
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    rst = 1'b0;
    @(negedge clk);

    // Continuous ramp frame: latency and frame length.
    push_expected(ramp_a, ramp_b);
    out_ready = 1'b1;
    cyc = 0;
    first_ov = 0;
    for (int e = 0; e < 18; e++) begin
      cyc++;
      check("stream_in_ready", in_ready, 1);
      in_valid = 1'b1;
      in_data = (e < 9) ? ramp_a[e] : ramp_b[e-9];
      @(negedge clk);
    end
    in_valid = 1'b0;
    done = 1'b0;
    n = 0;
    while (!done && n < 50) begin
      cyc++;
      check("excl_ready_valid", in_ready & out_valid, 0);
      if (out_valid) begin
        if (first_ov == 0) first_ov = cyc;
        exp_w = exp_q.pop_front();
        check("stream_word", {out_last, out_data}, exp_w);
        done = out_last;
      end else begin
        check("capture_busy", busy, 1);
      end
      @(negedge clk);
      n++;
    end
    check("stream_done", done, 1);
    check("first_out_valid_cycle", first_ov, 20);
    check("frame_cycles", cyc, 19 + NW);
    check("ready_after_last", in_ready, 1);
    check("idle_busy", busy, 0);
    out_ready = 1'b0;

    // Wrap-around: every element 512 gives all-zero products.
    send_frame(wrap_m, wrap_m, 1'b0);
    recv_frame(1'b0);

    // Random in_valid gaps and repeated output stalls.
    send_frame(ramp_a, ramp_b, 1'b1);
    recv_frame(1'b1);

    // Reset mid-frame after 11 operands discards the partial frame.
    for (int e = 0; e < 11; e++) send_elem((e < 9) ? wrap_m[e] : ident[e-9], 0);
    check("partial_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send_frame(ramp_a, ramp_b, 1'b0);
    recv_frame(1'b0);

    // Back-to-back frames.
    send_frame(ramp_a, ramp_b, 1'b0);
    recv_frame(1'b0);
    check("b2b_in_ready", in_ready, 1);
    send_frame(ident, ramp_b, 1'b0);
    recv_frame(1'b0);
    check("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
